// File: rtl/aes_cbc_ctrl_if.sv
// Bundles the config bus, plaintext/ciphertext streams and cipher-core handshake of aes_cbc_ctrl.
// The slave modport is the controller's view; the master modport is the host/core side.
interface aes_cbc_ctrl_if #(
  parameter int BW = 128,
  parameter int CW = 32
);
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          s_last;
  logic          core_req;
  logic [BW-1:0] core_key;
  logic [BW-1:0] core_din;
  logic          core_ack;
  logic [BW-1:0] core_dout;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          busy;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start,
    input  s_valid, s_data, s_last,
    input  core_ack, core_dout,
    input  m_ready,
    output s_ready, core_req, core_key, core_din,
    output m_valid, m_data, m_last, busy
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start,
    output s_valid, s_data, s_last,
    output core_ack, core_dout,
    output m_ready,
    input  s_ready, core_req, core_key, core_din,
    input  m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// AES-CBC chaining controller: holds key/IV/skip config, XORs each plaintext block with the
// running chain value, hands it to an external single-block cipher core and streams out ciphertext.
module aes_cbc_ctrl #(
  parameter int BW = 128,
  parameter int CW = 32
) (
  input logic          clk,
  input logic          rst_n,
  aes_cbc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CORE = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_key [4];
  logic [CW-1:0] r_iv  [4];
  logic [15:0]   r_skip;
  logic [15:0]   r_skip_cnt;
  logic [BW-1:0] r_chain;
  logic [BW-1:0] r_core_din;
  logic [BW-1:0] r_m_data;
  logic          r_last;
  logic          r_s_ready;
  logic          r_core_req;
  logic          r_m_valid;
  logic          r_m_last;
  logic          r_busy;
  logic [BW-1:0] w_iv;

  assign w_iv = {r_iv[0], r_iv[1], r_iv[2], r_iv[3]};

  assign bus.core_key = {r_key[0], r_key[1], r_key[2], r_key[3]};
  assign bus.core_din = r_core_din;
  assign bus.core_req = r_core_req;
  assign bus.s_ready  = r_s_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_data   = r_m_data;
  assign bus.m_last   = r_m_last;
  assign bus.busy     = r_busy;

  // Control FSM; every handshake output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      for (int i = 0; i < 4; i++) begin
        r_key[i] <= '0;
        r_iv[i]  <= '0;
      end
      r_skip     <= 16'd0;
      r_skip_cnt <= 16'd0;
      r_chain    <= '0;
      r_core_din <= '0;
      r_m_data   <= '0;
      r_last     <= 1'b0;
      r_s_ready  <= 1'b0;
      r_core_req <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cfg_we) begin
            case (bus.cfg_addr)
              4'd0, 4'd1, 4'd2, 4'd3: r_key[bus.cfg_addr[1:0]] <= bus.cfg_wdata;
              4'd4, 4'd5, 4'd6, 4'd7: r_iv[bus.cfg_addr[1:0]]  <= bus.cfg_wdata;
              4'd8:                   r_skip <= bus.cfg_wdata[15:0];
              default:                ;
            endcase
          end
          if (bus.start) begin
            r_chain    <= w_iv;
            r_skip_cnt <= r_skip;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            r_last <= bus.s_last;
            // Skipped blocks are consumed silently and never touch the chain value.
            if (r_skip_cnt != 16'd0) begin
              r_skip_cnt <= r_skip_cnt - 16'd1;
              if (bus.s_last) begin
                r_s_ready <= 1'b0;
                r_busy    <= 1'b0;
                r_state   <= IDLE;
              end
            end else begin
              r_core_din <= bus.s_data ^ r_chain;
              r_s_ready  <= 1'b0;
              r_core_req <= 1'b1;
              r_state    <= CORE;
            end
          end
        end
        CORE: begin
          if (bus.core_ack) begin
            r_m_data   <= bus.core_dout;
            r_chain    <= bus.core_dout;
            r_m_last   <= r_last;
            r_core_req <= 1'b0;
            r_m_valid  <= 1'b1;
            r_state    <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            r_m_valid <= 1'b0;
            if (r_m_last) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_s_ready <= 1'b1;
              r_state   <= LOAD;
            end
          end
        end
        default: begin
          r_s_ready  <= 1'b0;
          r_core_req <= 1'b0;
          r_m_valid  <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench for aes_cbc_ctrl: stimulus pushes expected ciphertext into a queue and an
// independent monitor pops and compares each accepted output block.
module tb_aes_cbc_ctrl;

  logic clk;
  logic rst_n;

  aes_cbc_ctrl_if #(.BW(128), .CW(32)) bus ();

  aes_cbc_ctrl #(.BW(128), .CW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   core_dly = 1;
  int   cyc_cnt = 0;
  logic [127:0] core_mask = 128'd0;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] BA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BB  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BC  = 128'hdeadbeefcafebabe1234567890abcdef;
  localparam logic [127:0] BD  = 128'h5555aaaa5555aaaa3333cccc3333cccc;
  localparam logic [127:0] IVX = 128'h80000000000000000000000000000001;
  localparam logic [127:0] IVY = 128'h13579bdf2468ace013579bdf2468ace0;
  localparam logic [127:0] MSK = 128'hf0f0f0f00f0f0f0fa5a5a5a55a5a5a5a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cipher core stub: acks after core_dly cycles of core_req, dout = din ^ core_mask.
  initial begin
    bus.core_ack  = 1'b0;
    bus.core_dout = 128'd0;
    forever begin
      @(posedge clk);
      #1;
      bus.core_ack = 1'b0;
      if (rst_n && bus.core_req) begin
        if (cyc_cnt == core_dly - 1) begin
          bus.core_ack  = 1'b1;
          bus.core_dout = bus.core_din ^ core_mask;
          cyc_cnt = 0;
        end else begin
          cyc_cnt++;
        end
      end else begin
        cyc_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: a block is transferred at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      exp_t e;
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h with none expected", bus.m_data);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", bus.m_data, e.data);
        chk("m_last", {127'd0, bus.m_last}, {127'd0, e.last});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_key(input logic [127:0] v);
    cfg_write(4'd0, v[127:96]);
    cfg_write(4'd1, v[95:64]);
    cfg_write(4'd2, v[63:32]);
    cfg_write(4'd3, v[31:0]);
  endtask

  task automatic set_iv(input logic [127:0] v);
    cfg_write(4'd4, v[127:96]);
    cfg_write(4'd5, v[95:64]);
    cfg_write(4'd6, v[63:32]);
    cfg_write(4'd7, v[31:0]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic push(input logic [127:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send_blk(input logic [127:0] d, input logic l);
    logic acc;
    int   k;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 200) begin
      acc = bus.s_ready;
      tick();
      k++;
    end
    bus.s_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    chk("idle_timeout", {127'd0, bus.busy}, 128'd0);
  endtask

  task automatic wait_mvalid();
    int k;
    k = 0;
    while (!bus.m_valid && k < 200) begin
      tick();
      k++;
    end
    chk("m_valid_timeout", {127'd0, bus.m_valid}, 128'd1);
  endtask

  initial begin
    logic [127:0] din0;
    logic [127:0] o1;
    int cnt;
    int out0;
    rst_n         = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = 4'd0;
    bus.cfg_wdata = 32'd0;
    bus.start     = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 128'd0;
    bus.s_last    = 1'b0;
    bus.m_ready   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_outputs", {120'd0, bus.busy, bus.s_ready, bus.core_req, bus.m_valid, bus.m_last, 3'd0}, 128'd0);
    chk("rst_m_data", bus.m_data, 128'd0);
    chk("rst_core_din", bus.core_din, 128'd0);
    chk("rst_core_key", bus.core_key, 128'd0);

    // Single block, identity core
    set_key(KEY);
    set_iv(IV1);
    chk("core_key", bus.core_key, KEY);
    push(~IV1, 1'b1);
    pulse_start();
    send_blk({128{1'b1}}, 1'b1);
    wait_idle();

    // Chaining across three blocks, then a fresh IV on the next operation
    set_iv(128'd0);
    push(BA, 1'b0);
    push(BA ^ BB, 1'b0);
    push(BA ^ BB ^ BC, 1'b1);
    pulse_start();
    send_blk(BA, 1'b0);
    send_blk(BB, 1'b0);
    send_blk(BC, 1'b1);
    wait_idle();
    set_iv(IVX);
    push(BD ^ IVX, 1'b1);
    pulse_start();
    send_blk(BD, 1'b1);
    wait_idle();

    // Chain must follow core output, not core input
    core_mask = MSK;
    set_iv(IVY);
    o1 = BA ^ IVY ^ MSK;
    push(o1, 1'b0);
    push(BB ^ o1 ^ MSK, 1'b1);
    pulse_start();
    send_blk(BA, 1'b0);
    send_blk(BB, 1'b1);
    wait_idle();
    core_mask = 128'd0;

    // Skip two of four blocks
    cfg_write(4'd8, 32'h0000_0002);
    out0 = n_out;
    push(BC ^ IVY, 1'b0);
    push(BD ^ BC ^ IVY, 1'b1);
    pulse_start();
    send_blk(BA, 1'b0);
    send_blk(BB, 1'b0);
    send_blk(BC, 1'b0);
    send_blk(BD, 1'b1);
    wait_idle();
    chk("skip2_out_count", 128'(n_out - out0), 128'd2);

    // Skip one with a single last block: no output at all
    cfg_write(4'd8, 32'h0000_0001);
    out0 = n_out;
    pulse_start();
    send_blk(BA, 1'b1);
    tick();
    chk("skip1_busy", {127'd0, bus.busy}, 128'd0);
    repeat (3) tick();
    chk("skip1_out_count", 128'(n_out - out0), 128'd0);
    cfg_write(4'd8, 32'h0000_0000);

    // Backpressure and slow core
    set_iv(IV1);
    bus.m_ready = 1'b0;
    core_dly = 3;
    push(BB ^ IV1, 1'b1);
    pulse_start();
    send_blk(BB, 1'b1);
    din0 = bus.core_din;
    chk("core_din_value", din0, BB ^ IV1);
    cnt = 0;
    while (bus.core_req && cnt < 10) begin
      chk("core_din_stable", bus.core_din, din0);
      tick();
      cnt++;
    end
    chk("core_req_cycles", 128'(cnt), 128'd3);
    chk("m_valid_latency", {127'd0, bus.m_valid}, 128'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_m_valid", {127'd0, bus.m_valid}, 128'd1);
      chk("bp_m_data", bus.m_data, BB ^ IV1);
      chk("bp_s_ready", {127'd0, bus.s_ready}, 128'd0);
      tick();
    end
    bus.m_ready = 1'b1;
    wait_idle();
    core_dly = 1;

    // Config write and start while busy are dropped
    bus.m_ready = 1'b0;
    out0 = n_out;
    push(BC ^ IV1, 1'b1);
    pulse_start();
    send_blk(BC, 1'b1);
    wait_mvalid();
    cfg_write(4'd0, 32'hdeadbeef);
    pulse_start();
    chk("busy_key_write", bus.core_key, KEY);
    bus.m_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("busy_start_ignored", {127'd0, bus.busy}, 128'd0);
    chk("busy_out_count", 128'(n_out - out0), 128'd1);

    // Reset in the middle of CORE
    core_dly = 50;
    pulse_start();
    send_blk(BD, 1'b1);
    chk("pre_rst_core_req", {127'd0, bus.core_req}, 128'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_core_req", {127'd0, bus.core_req}, 128'd0);
    chk("rst_mid_busy", {127'd0, bus.busy}, 128'd0);
    tick();
    rst_n = 1'b1;
    core_dly = 1;
    tick();
    chk("post_rst_key", bus.core_key, 128'd0);
    chk("post_rst_din", bus.core_din, 128'd0);
    push(BA, 1'b1);
    pulse_start();
    send_blk(BA, 1'b1);
    chk("post_rst_key_op", bus.core_key, 128'd0);
    wait_idle();

    repeat (3) tick();
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
